parallel_to_serial: RTL and testbench

Splits one P_WIDTH-bit parallel word into P_WIDTH/S_WIDTH consecutive S_WIDTH-bit chunks, most-significant chunk first. It is the transmit-side counterpart of the serial-to-parallel packer: a word split here and re-packed by that block reproduces the original word. It sits between the 64-bit payload source and the byte-wide UART transmitter. Both sides use valid/ready handshakes, so the UART can stall the stream per chunk.

---
 rtl/parallel_to_serial.sv | 155 +++++++++++++++
 tb/tb_parallel_to_serial.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parallel_to_serial.sv
// parallel_to_serial: splits one P_WIDTH-bit word into P_WIDTH/S_WIDTH
// S_WIDTH-bit chunks, most-significant chunk first, with valid/ready on both
// sides so the downstream transmitter can stall each chunk.
//
// Optional feature macro: P2S_PREFETCH_EN
//   defined   -> one-word hold register; the next word is accepted while the
//                current one is still shifting, giving gap-free output.
//   undefined -> a word is only accepted while idle, so consecutive words are
//                separated by one cycle with out_valid low.
//
// Every output is decoded from registers only; no input reaches an output
// combinationally.
module parallel_to_serial #(
  parameter int S_WIDTH = 8,
  parameter int P_WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [P_WIDTH-1:0] in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [S_WIDTH-1:0] out_data,
  output logic               out_last,
  input  logic               out_ready,
  output logic               busy
);

  // Number of chunks per word and the counter that walks through them.
  localparam int COUNT_MAX = P_WIDTH / S_WIDTH;
  localparam int CNT_W     = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_MAX - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             state;
  logic [P_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]   counter;
  logic               hold_valid;

  // Handshake events seen at the next rising edge.
  logic accept;
  logic xfer;
  logic xfer_last;

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign xfer_last = xfer & (counter == CNT_LAST);

  // Output decode, purely from state/shift_reg/counter/hold_valid.
  assign out_valid = (state == SHIFT);
  assign out_data  = shift_reg[P_WIDTH-1 -: S_WIDTH];
  assign out_last  = out_valid & (counter == CNT_LAST);
  assign busy      = out_valid | hold_valid;

`ifdef P2S_PREFETCH_EN
  logic [P_WIDTH-1:0] hold_reg;

  // The hold slot being empty is the only condition for taking a new word;
  // while idle the slot is always empty, so idle also means ready.
  assign in_ready = ~hold_valid;

  // Word sequencing with prefetch: idle load, chunk shifting, hold slot
  // refill and gap-free handover from hold (or bypass) on the last chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      shift_reg  <= '0;
      counter    <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Idle accepts go straight to the shifter, never to the hold slot.
          if (accept) begin
            shift_reg <= in_data;
            counter   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (counter != CNT_LAST) begin
              shift_reg <= {shift_reg[P_WIDTH-S_WIDTH-1:0], {S_WIDTH{1'b0}}};
              counter   <= counter + 1'b1;
            end else begin
              counter <= '0;
              if (hold_valid) begin
                // Held word takes over with no idle cycle.
                shift_reg  <= hold_reg;
                hold_valid <= 1'b0;
              end else if (accept) begin
                // Hold empty but a word arrives right now: bypass the slot.
                shift_reg <= in_data;
              end else begin
                state <= IDLE;
              end
            end
          end
          // A word arriving mid-stream parks in the hold slot; on a last
          // transfer it has already been steered into the shifter above.
          // accept implies the slot is empty, so this never collides with
          // the hold_valid clear above.
          if (accept && !xfer_last) begin
            hold_reg   <= in_data;
            hold_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  // Without the hold slot a word can only be taken while idle.
  assign hold_valid = 1'b0;
  assign in_ready   = (state == IDLE);

  // Word sequencing: idle load, chunk shifting, return to idle after the
  // last chunk (which creates the one-cycle gap between words).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      counter   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= in_data;
            counter   <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (xfer) begin
            if (counter != CNT_LAST) begin
              shift_reg <= {shift_reg[P_WIDTH-S_WIDTH-1:0], {S_WIDTH{1'b0}}};
              counter   <= counter + 1'b1;
            end else begin
              counter <= '0;
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_parallel_to_serial.sv
// Directed bench for parallel_to_serial: a 64/8 instance for the main
// scenarios and a 16/8 instance for the two-chunk (1-bit counter) case.
// Honours P2S_PREFETCH_EN so the same bench covers both builds.
module tb_parallel_to_serial;

`ifdef P2S_PREFETCH_EN
  localparam logic PREF = 1'b1;
`else
  localparam logic PREF = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic        busy;

  logic        n_in_valid;
  logic [15:0] n_in_data;
  logic        n_in_ready;
  logic        n_out_valid;
  logic [7:0]  n_out_data;
  logic        n_out_last;
  logic        n_out_ready;
  logic        n_busy;

  int total;
  int bad;

  logic [7:0] exp_single [8] = '{8'h01, 8'h23, 8'h45, 8'h67,
                                 8'h89, 8'hAB, 8'hCD, 8'hEF};

  parallel_to_serial #(.S_WIDTH(8), .P_WIDTH(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  parallel_to_serial #(.S_WIDTH(8), .P_WIDTH(16)) dut_n (
    .clk(clk), .rst(rst),
    .in_valid(n_in_valid), .in_data(n_in_data), .in_ready(n_in_ready),
    .out_valid(n_out_valid), .out_data(n_out_data), .out_last(n_out_last),
    .out_ready(n_out_ready), .busy(n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One line per chunk transfer.
  always @(posedge clk) begin
    if (!rst && out_valid && out_ready)
      $display("xfer64 data=%h last=%b", out_data, out_last);
    if (!rst && n_out_valid && n_out_ready)
      $display("xfer16 data=%h last=%b", n_out_data, n_out_last);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  // Chunk i (MSB first) of a 64-bit word.
  function automatic logic [7:0] chunk_of(input logic [63:0] w, input int i);
    logic [63:0] t;
    t = w << (8 * i);
    return t[63:56];
  endfunction

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_out_data got=%h want=00", out_data); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_out_last got=%b want=0", out_last); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_single[i]) begin
        bad++; $display("FAIL single_chunk%0d got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, exp_single[i]);
      end
      total++;
      if (out_last !== logic'(i == 7)) begin
        bad++; $display("FAIL single_last%0d got=%b want=%b", i, out_last, logic'(i == 7));
      end
      total++;
      if (in_ready !== PREF) begin
        bad++; $display("FAIL single_in_ready%0d got=%b want=%b", i, in_ready, PREF);
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL single_end got valid=%b ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_single[i]) begin
        bad++; $display("FAIL stall_first%0d got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, exp_single[i]);
      end
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_single[i] || out_last !== logic'(i == 7)) begin
        bad++; $display("FAIL stall_held%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b", i, out_valid, out_data, out_last, exp_single[i], logic'(i == 7));
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_end got valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    in_valid = 1'b1; in_data = {8{8'h11}}; out_ready = 1'b1;
    @(negedge clk);
    in_data = {8{8'h22}};
`ifdef P2S_PREFETCH_EN
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        in_valid = 1'b0;
        total++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          bad++; $display("FAIL b2b_hold_full got ready=%b busy=%b want 0/1", in_ready, busy);
        end
      end
      total++;
      if (out_valid !== 1'b1 || out_data !== ((k < 8) ? 8'h11 : 8'h22) || out_last !== logic'(k == 7 || k == 15)) begin
        bad++; $display("FAIL b2b_chunk%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b", k, out_valid, out_data, out_last, (k < 8) ? 8'h11 : 8'h22, logic'(k == 7 || k == 15));
      end
    end
`else
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h11 || out_last !== logic'(k == 7)) begin
        bad++; $display("FAIL b2b_first%0d got valid=%b data=%h last=%b want valid=1 data=11 last=%b", k, out_valid, out_data, out_last, logic'(k == 7));
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_gap got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== 8'h22 || out_last !== logic'(k == 7)) begin
        bad++; $display("FAIL b2b_second%0d got valid=%b data=%h last=%b want valid=1 data=22 last=%b", k, out_valid, out_data, out_last, logic'(k == 7));
      end
    end
`endif
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL b2b_end got valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_pulse();
    logic [63:0] w3;
    w3 = 64'hCAFEBABEDEADBEEF;
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) begin
        in_valid = 1'b1; in_data = w3;
        total++;
        if (in_ready !== PREF) begin
          bad++; $display("FAIL pulse_in_ready got=%b want=%b", in_ready, PREF);
        end
      end
`ifdef P2S_PREFETCH_EN
      if (i == 4) in_valid = 1'b0;
`endif
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_single[i]) begin
        bad++; $display("FAIL pulse_first%0d got valid=%b data=%h want valid=1 data=%h", i, out_valid, out_data, exp_single[i]);
      end
    end
`ifndef P2S_PREFETCH_EN
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL pulse_gap got valid=%b ready=%b want 0/1", out_valid, in_ready);
    end
`endif
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      if (j == 0) in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== chunk_of(w3, j) || out_last !== logic'(j == 7)) begin
        bad++; $display("FAIL pulse_second%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b", j, out_valid, out_data, out_last, chunk_of(w3, j), logic'(j == 7));
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL pulse_end got valid=%b busy=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_async_reset();
    logic [63:0] wn;
    wn = 64'hFEDCBA9876543210;
    @(negedge clk);
    in_valid = 1'b1; in_data = 64'h0123456789ABCDEF; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (out_data !== 8'h67) begin
      bad++; $display("FAIL rst_pre_chunk got=%h want=67", out_data);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_async got valid=%b last=%b busy=%b ready=%b want 0/0/0/1", out_valid, out_last, busy, in_ready);
    end
    #1 rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = wn;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1 || out_data !== chunk_of(wn, j) || out_last !== logic'(j == 7)) begin
        bad++; $display("FAIL rst_new%0d got valid=%b data=%h last=%b want valid=1 data=%h last=%b", j, out_valid, out_data, out_last, chunk_of(wn, j), logic'(j == 7));
      end
    end
    @(negedge clk);
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL rst_end got valid=%b want=0", out_valid);
    end
  endtask

  task automatic test_narrow();
    logic [15:0] words [2];
    words[0] = 16'hA55A;
    words[1] = 16'h1234;
    for (int w = 0; w < 2; w++) begin
      @(negedge clk);
      n_in_valid = 1'b1; n_in_data = words[w]; n_out_ready = 1'b1;
      @(negedge clk);
      n_in_valid = 1'b0;
      total++;
      if (n_out_valid !== 1'b1 || n_out_data !== words[w][15:8] || n_out_last !== 1'b0 || n_in_ready !== PREF) begin
        bad++; $display("FAIL narrow_hi%0d got valid=%b data=%h last=%b ready=%b want valid=1 data=%h last=0 ready=%b", w, n_out_valid, n_out_data, n_out_last, n_in_ready, words[w][15:8], PREF);
      end
      @(negedge clk);
      total++;
      if (n_out_valid !== 1'b1 || n_out_data !== words[w][7:0] || n_out_last !== 1'b1) begin
        bad++; $display("FAIL narrow_lo%0d got valid=%b data=%h last=%b want valid=1 data=%h last=1", w, n_out_valid, n_out_data, n_out_last, words[w][7:0]);
      end
      @(negedge clk);
      total++;
      if (n_out_valid !== 1'b0 || n_in_ready !== 1'b1) begin
        bad++; $display("FAIL narrow_end%0d got valid=%b ready=%b want 0/1", w, n_out_valid, n_in_ready);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_pulse();
    test_async_reset();
    test_narrow();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
